div_n_bit_seq: RTL and testbench

//  Iterative N-bit integer divider, the inverse datapath of the combinational

---
 rtl/div_n_bit_seq.sv | 133 +++++++++++++
 tb/tb_div_n_bit_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/div_n_bit_seq.sv
// Iterative restoring divider (signed/unsigned), one quotient bit per clock, Start/Busy/Done handshake.
// Optional `DIV_ZERO_FLAG_EN adds a registered DivZero output.
module div_n_bit_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         Start,
  input  logic         Signed,
  input  logic         QuoRem,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Out
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic         DivZero
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int CW = $clog2(N + 1);

  function automatic logic [N-1:0] cneg(input logic [N-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  p_q, p_d;
  logic          sgnq_q, sgnq_d;
  logic          sgnr_q, sgnr_d;
  logic [N:0]    p_sh;
  logic [N:0]    diff;
  logic          ge;

  // a_q starts as |X| and fills with quotient bits as the dividend shifts out
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    p_sh    = {p_q, a_q[N-1]};
    diff    = p_sh - {1'b0, b_q};
    ge      = ~diff[N];
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = cneg(X, Signed & X[N-1]);
          b_d     = cneg(Y, Signed & Y[N-1]);
          p_d     = '0;
          sgnq_d  = Signed & (X[N-1] ^ Y[N-1]);
          sgnr_d  = Signed & X[N-1];
          count_d = CW'(N);
          dz_d    = (Y == '0);
          state_d = (Y == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        p_d     = ge ? diff[N-1:0] : p_sh[N-1:0];
        a_d     = {a_q[N-2:0], ge};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // Divide by zero: a_q still holds |X|, so re-applying the sign restores X
        quo_d   = dz_q ? '1 : cneg(a_q, sgnq_q);
        rem_d   = dz_q ? cneg(a_q, sgnr_q) : cneg(p_q, sgnr_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    p_q    <= p_d;
    sgnq_q <= sgnq_d;
    sgnr_q <= sgnr_d;
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dzf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                dzf_q <= 1'b0;
    else if (state_q == FIX) dzf_q <= dz_q;
  end

  assign DivZero = dzf_q;
`endif

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign Out  = QuoRem ? rem_q : quo_q;

endmodule

// File: tb/tb_div_n_bit_seq.sv
// Directed testbench for div_n_bit_seq (N=32); checks DivZero too when DIV_ZERO_FLAG_EN is defined.
module tb_div_n_bit_seq;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] X = '0;
  logic [N-1:0] Y = '0;
  logic         Start = 1'b0;
  logic         Signed = 1'b0;
  logic         QuoRem = 1'b0;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Out;
`ifdef DIV_ZERO_FLAG_EN
  logic         DivZero;
`endif

  int ntests = 0;
  int nfail  = 0;
  int cyc;
  logic [N-1:0] q, r;

  div_n_bit_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .Start(Start), .Signed(Signed),
    .QuoRem(QuoRem), .Busy(Busy), .Done(Done), .Out(Out)
`ifdef DIV_ZERO_FLAG_EN
    , .DivZero(DivZero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Launch one op and count negedges after the accept edge until Done (bounded)
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                        output int c);
    @(negedge clk);
    X = x; Y = y; Signed = s; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    c = 0;
    while (!Done && c < 100) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic read_qr(output logic [N-1:0] qq, output logic [N-1:0] rr);
    QuoRem = 1'b0; #1; qq = Out;
    QuoRem = 1'b1; #1; rr = Out;
    QuoRem = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    read_qr(q, r);
    ntests++; if (Busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    ntests++; if (Done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %b expected 0", Done); end
    ntests++; if (q !== '0) begin nfail++; $display("FAIL reset_q: got %h expected 0", q); end
    ntests++; if (r !== '0) begin nfail++; $display("FAIL reset_r: got %h expected 0", r); end
`ifdef DIV_ZERO_FLAG_EN
    ntests++; if (DivZero !== 1'b0) begin nfail++; $display("FAIL reset_dz: got %b expected 0", DivZero); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    @(negedge clk);
    X = 32'd100; Y = 32'd7; Signed = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    ntests++; if (Busy !== 1'b1) begin nfail++; $display("FAIL udiv_busy: got %b expected 1", Busy); end
    cyc = 0;
    while (!Done && cyc < 100) begin @(negedge clk); cyc++; end
    ntests++; if (cyc != N + 1) begin nfail++; $display("FAIL udiv_latency: got %0d expected %0d", cyc, N + 1); end
    ntests++; if (Busy !== 1'b0) begin nfail++; $display("FAIL udiv_busy_done: got %b expected 0", Busy); end
    read_qr(q, r);
    ntests++; if (q !== 32'd14) begin nfail++; $display("FAIL udiv_q: got %h expected %h", q, 32'd14); end
    ntests++; if (r !== 32'd2) begin nfail++; $display("FAIL udiv_r: got %h expected %h", r, 32'd2); end
    @(negedge clk);
    ntests++; if (Done !== 1'b0) begin nfail++; $display("FAIL udiv_done_pulse: got %b expected 0", Done); end
    read_qr(q, r);
    ntests++; if (q !== 32'd14) begin nfail++; $display("FAIL udiv_q_hold: got %h expected %h", q, 32'd14); end
  endtask

  task automatic test_signed;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, cyc);
    read_qr(q, r);
    ntests++; if (q !== 32'hFFFF_FFFD) begin nfail++; $display("FAIL sdiv_m7_q: got %h expected FFFFFFFD", q); end
    ntests++; if (r !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL sdiv_m7_r: got %h expected FFFFFFFF", r); end
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, cyc);
    read_qr(q, r);
    ntests++; if (q !== 32'hFFFF_FFFD) begin nfail++; $display("FAIL sdiv_7m2_q: got %h expected FFFFFFFD", q); end
    ntests++; if (r !== 32'd1) begin nfail++; $display("FAIL sdiv_7m2_r: got %h expected 1", r); end
    // Same bits unsigned: 7 / 0xFFFFFFFE = 0 rem 7
    run_op(32'd7, 32'hFFFF_FFFE, 1'b0, cyc);
    read_qr(q, r);
    ntests++; if (q !== 32'd0) begin nfail++; $display("FAIL udiv_7big_q: got %h expected 0", q); end
    ntests++; if (r !== 32'd7) begin nfail++; $display("FAIL udiv_7big_r: got %h expected 7", r); end
  endtask

  task automatic test_div_zero;
    for (int s = 0; s < 2; s++) begin
      run_op(32'd5, 32'd0, s[0], cyc);
      ntests++; if (cyc != 1) begin nfail++; $display("FAIL dz_latency s=%0d: got %0d expected 1", s, cyc); end
      read_qr(q, r);
      ntests++; if (q !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL dz_q s=%0d: got %h expected FFFFFFFF", s, q); end
      ntests++; if (r !== 32'd5) begin nfail++; $display("FAIL dz_r s=%0d: got %h expected 5", s, r); end
`ifdef DIV_ZERO_FLAG_EN
      ntests++; if (DivZero !== 1'b1) begin nfail++; $display("FAIL dz_flag s=%0d: got %b expected 1", s, DivZero); end
`endif
    end
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, cyc);
    read_qr(q, r);
    ntests++; if (r !== 32'hFFFF_FFF9) begin nfail++; $display("FAIL dz_neg_r: got %h expected FFFFFFF9", r); end
  endtask

  task automatic test_overflow;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc);
    read_qr(q, r);
    ntests++; if (q !== 32'h8000_0000) begin nfail++; $display("FAIL ovf_q: got %h expected 80000000", q); end
    ntests++; if (r !== 32'd0) begin nfail++; $display("FAIL ovf_r: got %h expected 0", r); end
`ifdef DIV_ZERO_FLAG_EN
    ntests++; if (DivZero !== 1'b0) begin nfail++; $display("FAIL dz_clear: got %b expected 0", DivZero); end
`endif
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, cyc);
    read_qr(q, r);
    ntests++; if (q !== 32'hFFFF_FFFF) begin nfail++; $display("FAIL umax_q: got %h expected FFFFFFFF", q); end
    ntests++; if (r !== 32'd0) begin nfail++; $display("FAIL umax_r: got %h expected 0", r); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    X = 32'd100; Y = 32'd7; Signed = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (5) @(negedge clk);
    X = 32'd50; Y = 32'd5; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    cyc = 6;
    while (!Done && cyc < 100) begin @(negedge clk); cyc++; end
    ntests++; if (cyc != N + 1) begin nfail++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, N + 1); end
    read_qr(q, r);
    ntests++; if (q !== 32'd14) begin nfail++; $display("FAIL ignore_q: got %h expected %h", q, 32'd14); end
    ntests++; if (r !== 32'd2) begin nfail++; $display("FAIL ignore_r: got %h expected %h", r, 32'd2); end
    // Start on the Done cycle
    X = 32'd50; Y = 32'd5; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    cyc = 1;
    while (!Done && cyc < 100) begin @(negedge clk); cyc++; end
    ntests++; if (cyc != N + 2) begin nfail++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, N + 2); end
    read_qr(q, r);
    ntests++; if (q !== 32'd10) begin nfail++; $display("FAIL b2b_q: got %h expected %h", q, 32'd10); end
    ntests++; if (r !== 32'd0) begin nfail++; $display("FAIL b2b_r: got %h expected 0", r); end
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    X = 32'd100; Y = 32'd7; Signed = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    ntests++; if (Busy !== 1'b0) begin nfail++; $display("FAIL abort_busy: got %b expected 0", Busy); end
    read_qr(q, r);
    ntests++; if (q !== '0) begin nfail++; $display("FAIL abort_q: got %h expected 0", q); end
    ntests++; if (r !== '0) begin nfail++; $display("FAIL abort_r: got %h expected 0", r); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (N + 5) begin
      @(negedge clk);
      if (Done) seen = 1;
    end
    ntests++; if (seen != 0) begin nfail++; $display("FAIL abort_no_done: got %0d expected 0", seen); end
    run_op(32'd1000, 32'd10, 1'b0, cyc);
    ntests++; if (cyc != N + 1) begin nfail++; $display("FAIL abort_retry_latency: got %0d expected %0d", cyc, N + 1); end
    read_qr(q, r);
    ntests++; if (q !== 32'd100) begin nfail++; $display("FAIL abort_retry_q: got %h expected %h", q, 32'd100); end
    ntests++; if (r !== 32'd0) begin nfail++; $display("FAIL abort_retry_r: got %h expected 0", r); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
